// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
//
// Shared definitions for the RISC datapath shift/rotate unit.
//   SHIFT_W     : datapath width. The shift amount is 5 bits, so this is 32.
//   SH_AMT_W    : width of the shift amount field.
//   shift_ftn_e : function select encoding driven on the 'ftn' port.
//   neg_amount  : (32 - amount) mod 32. It turns a left rotate into the
//                 equivalent right rotate.
// ---------------------------------------------------------------------------
package shifter_pkg;

    localparam int SHIFT_W  = 32;
    localparam int SH_AMT_W = 5;

    typedef enum logic [2:0] {
        SH_PASS = 3'd0,
        SH_SLL  = 3'd1,
        SH_SRL  = 3'd2,
        SH_SRA  = 3'd3,
        SH_ROL  = 3'd4,
        SH_ROR  = 3'd5,
        SH_REV  = 3'd6,
        SH_ZERO = 3'd7
    } shift_ftn_e;

    // Two's-complement negate in 5 bits. This equals (32 - amount) mod 32.
    // An amount of 0 stays 0.
    function automatic logic [SH_AMT_W-1:0] neg_amount(input logic [SH_AMT_W-1:0] amount);
        return (~amount) + {{(SH_AMT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/risc_rotr_core.sv
// ---------------------------------------------------------------------------
// risc_rotr_core
//
// Combinational right-rotate barrel. It uses five mux stages. Stage s
// rotates by 2**s when amount[s] is set.
//
// Ports:
//   data_in  [WIDTH-1:0] : operand
//   amount   [4:0]       : rotate-right distance, 0..31
//   data_out [WIDTH-1:0] : data_in rotated right by amount
// ---------------------------------------------------------------------------
module risc_rotr_core
    import shifter_pkg::*;
#(
    parameter int WIDTH = SHIFT_W
) (
    input  logic [WIDTH-1:0]    data_in,
    input  logic [SH_AMT_W-1:0] amount,
    output logic [WIDTH-1:0]    data_out
);

    // stage[0] is the raw operand. stage[SH_AMT_W] is the fully rotated value.
    logic [WIDTH-1:0] stage [0:SH_AMT_W];

    assign stage[0] = data_in;

    for (genvar s = 0; s < SH_AMT_W; s++) begin : g_stage
        localparam int STEP = 1 << s;
        // To rotate right by STEP, the low STEP bits wrap round to the top.
        assign stage[s+1] = amount[s]
                          ? {stage[s][STEP-1:0], stage[s][WIDTH-1:STEP]}
                          : stage[s];
    end

    assign data_out = stage[SH_AMT_W];

endmodule

// File: rtl/risc_shifter.sv
// ---------------------------------------------------------------------------
// risc_shifter
//
// Registered 32-bit shift/rotate unit. It sits beside the ALU. It applies
// the operation selected by 'ftn' to 'shift_in' by 'SH' bits. The result
// appears on 'shift_out' one clock after in_valid is sampled high.
//
// One right-rotate barrel handles every shift and rotate:
//   - Right ops rotate by SH.
//   - Left ops rotate right by (32 - SH) mod 32.
//   - Shifts then mask off the wrapped bits and OR in the fill bits.
//
// Optional feature macro: SHIFTER_FLAGS_EN
//   When it is defined, carry_out and zero are registered with shift_out.
//   When it is undefined, those ports and their logic are absent.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous reset, active low
//   in_valid  : shift_in, SH and ftn are sampled this cycle
//   shift_in  : operand
//   SH        : shift amount, 0..31
//   ftn       : function select (see shifter_pkg::shift_ftn_e)
//   out_valid : shift_out holds a new result (in_valid delayed by 1 clock)
//   shift_out : registered result, held while in_valid is low
//   carry_out : last bit shifted out, or the wrapped bit for rotates
//               (SHIFTER_FLAGS_EN only)
//   zero      : result equals 0 (SHIFTER_FLAGS_EN only)
// ---------------------------------------------------------------------------
module risc_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = SHIFT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    shift_in,
    input  logic [SH_AMT_W-1:0] SH,
    input  logic [2:0]          ftn,
    output logic                out_valid,
    output logic [WIDTH-1:0]    shift_out
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic                carry_out,
    output logic                zero
`endif
);

    shift_ftn_e          ftn_e;
    logic                left_op;
    logic [SH_AMT_W-1:0] rot_amt;
    logic [WIDTH-1:0]    rotated;
    logic [WIDTH-1:0]    mask_left;
    logic [WIDTH-1:0]    mask_right;
    logic [WIDTH-1:0]    reversed;
    logic [WIDTH-1:0]    result;

    logic [WIDTH-1:0]    shift_out_q, shift_out_d;
    logic                out_valid_q, out_valid_d;

    assign ftn_e = shift_ftn_e'(ftn);

    // SLL and ROL are left-going. They reuse the right rotator with the
    // complementary amount.
    always_comb begin
        left_op = (ftn_e == SH_SLL) || (ftn_e == SH_ROL);
        rot_amt = left_op ? neg_amount(SH) : SH;
    end

    risc_rotr_core #(
        .WIDTH (WIDTH)
    ) u_rotr_core (
        .data_in  (shift_in),
        .amount   (rot_amt),
        .data_out (rotated)
    );

    // A left shift keeps the bits at and above SH. A right shift keeps the
    // bits below WIDTH-SH. Every other bit of the rotated value has wrapped
    // round and must be replaced with fill.
    always_comb begin
        mask_left  = {WIDTH{1'b1}} << SH;
        mask_right = {WIDTH{1'b1}} >> SH;
    end

    always_comb begin
        reversed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            reversed[i] = shift_in[WIDTH-1-i];
        end
    end

    always_comb begin
        result = '0;
        unique case (ftn_e)
            SH_PASS: result = shift_in;
            SH_SLL:  result = rotated & mask_left;
            SH_SRL:  result = rotated & mask_right;
            SH_SRA:  result = (rotated & mask_right)
                            | (shift_in[WIDTH-1] ? ~mask_right : '0);
            SH_ROL:  result = rotated;
            SH_ROR:  result = rotated;
            SH_REV:  result = reversed;
            SH_ZERO: result = '0;
            default: result = '0;
        endcase
    end

    // The result only updates on a valid sample. Otherwise it holds.
    always_comb begin
        shift_out_d = in_valid ? result : shift_out_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            shift_out_q <= shift_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign shift_out = shift_out_q;
    assign out_valid = out_valid_q;

`ifdef SHIFTER_FLAGS_EN
    logic                carry_q, carry_d;
    logic                zero_q, zero_d;
    logic                carry_now;
    logic [SH_AMT_W-1:0] sh_minus_1;

    // SLL drops shift_in[32-SH] last. For a nonzero SH this index is the
    // 5-bit negated amount. SRL and SRA drop shift_in[SH-1] last.
    always_comb begin
        sh_minus_1 = SH - {{(SH_AMT_W-1){1'b0}}, 1'b1};
        carry_now  = 1'b0;
        if (SH != '0) begin
            unique case (ftn_e)
                SH_SLL:  carry_now = shift_in[neg_amount(SH)];
                SH_SRL:  carry_now = shift_in[sh_minus_1];
                SH_SRA:  carry_now = shift_in[sh_minus_1];
                SH_ROL:  carry_now = result[0];
                SH_ROR:  carry_now = result[WIDTH-1];
                default: carry_now = 1'b0;
            endcase
        end
    end

    always_comb begin
        carry_d = in_valid ? carry_now        : carry_q;
        zero_d  = in_valid ? (result == '0)   : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry_out = carry_q;
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_risc_shifter.sv
// ---------------------------------------------------------------------------
// tb_risc_shifter
//
// Directed testbench for risc_shifter. All expected values are computed by
// hand. Flag checks are included when SHIFTER_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_risc_shifter;

    logic        clock;
    logic        resetN;
    logic        inValid;
    logic [31:0] shiftIn;
    logic [4:0]  shAmt;
    logic [2:0]  ftnSel;
    logic        outValid;
    logic [31:0] shiftOut;
`ifdef SHIFTER_FLAGS_EN
    logic        carryOut;
    logic        zeroFlag;
`endif

    int checkCount = 0;
    int errorCount = 0;

    risc_shifter dut (
        .clk       (clock),
        .rst_n     (resetN),
        .in_valid  (inValid),
        .shift_in  (shiftIn),
        .SH        (shAmt),
        .ftn       (ftnSel),
        .out_valid (outValid),
        .shift_out (shiftOut)
`ifdef SHIFTER_FLAGS_EN
        ,
        .carry_out (carryOut),
        .zero      (zeroFlag)
`endif
    );

    // 10 ns clock period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so that a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, observed, expected);
        end
    endtask

    // Drives the inputs. Callers do this away from the rising edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                 input logic [4:0] amt, input logic [2:0] fsel);
        inValid = valid;
        shiftIn = data;
        shAmt   = amt;
        ftnSel  = fsel;
    endtask

    // Starts at a negedge and issues one operation. It checks the result at
    // the following negedge, one clock edge later. Repeated calls keep
    // in_valid high from one cycle to the next.
    task automatic runOp(input string tag, input logic [31:0] data,
                         input logic [4:0] amt, input logic [2:0] fsel,
                         input logic [31:0] expected);
        applyStimulus(1'b1, data, amt, fsel);
        @(negedge clock);
        checkOutput(tag, shiftOut, expected);
        checkOutput({tag, "_valid"}, {31'b0, outValid}, 32'd1);
    endtask

    logic [31:0] sweepExp [0:7];

    initial begin
        sweepExp[0] = 32'h35FFFF15;
        sweepExp[1] = 32'hFFFF1500;
        sweepExp[2] = 32'h0035FFFF;
        sweepExp[3] = 32'h0035FFFF;
        sweepExp[4] = 32'hFFFF1535;
        sweepExp[5] = 32'h1535FFFF;
        sweepExp[6] = 32'hA8FFFFAC;
        sweepExp[7] = 32'h00000000;

        // Hold reset while in_valid is high. All outputs must stay 0.
        resetN = 1'b0;
        applyStimulus(1'b1, 32'h35FFFF15, 5'd8, 3'd1);
        repeat (3) @(negedge clock);
        checkOutput("reset_out", shiftOut, 32'h0);
        checkOutput("reset_valid", {31'b0, outValid}, 32'h0);
`ifdef SHIFTER_FLAGS_EN
        checkOutput("reset_carry", {31'b0, carryOut}, 32'h0);
        checkOutput("reset_zero", {31'b0, zeroFlag}, 32'h0);
`endif

        // Release reset with in_valid low. No result may appear.
        resetN = 1'b1;
        applyStimulus(1'b0, 32'h0, 5'd0, 3'd0);
        @(negedge clock);
        checkOutput("idle_valid", {31'b0, outValid}, 32'h0);
        checkOutput("idle_out", shiftOut, 32'h0);

        // Step through all eight functions back-to-back.
        for (int f = 0; f < 8; f++) begin
            runOp($sformatf("sweep_f%0d", f), 32'h35FFFF15, 5'd8, 3'(f), sweepExp[f]);
        end

        // Sign fill
        runOp("sra_sign", 32'h85FFFF15, 5'd8, 3'd3, 32'hFF85FFFF);
        runOp("srl_sign", 32'h85FFFF15, 5'd8, 3'd2, 32'h0085FFFF);

        // SH = 0 leaves the operand unchanged for every shift and rotate.
        for (int f = 1; f <= 5; f++) begin
            runOp($sformatf("sh0_f%0d", f), 32'h35FFFF15, 5'd0, 3'(f), 32'h35FFFF15);
        end

        // Maximum shift amount
        runOp("sll_31", 32'h00000001, 5'd31, 3'd1, 32'h80000000);
        runOp("sra_31", 32'h80000000, 5'd31, 3'd3, 32'hFFFFFFFF);

`ifdef SHIFTER_FLAGS_EN
        runOp("flag_sll", 32'h35FFFF15, 5'd8, 3'd1, 32'hFFFF1500);
        checkOutput("carry_sll", {31'b0, carryOut}, 32'd1);
        checkOutput("zero_sll", {31'b0, zeroFlag}, 32'd0);
        runOp("flag_srl", 32'h35FFFF15, 5'd8, 3'd2, 32'h0035FFFF);
        checkOutput("carry_srl", {31'b0, carryOut}, 32'd0);
        runOp("flag_zero", 32'h35FFFF15, 5'd8, 3'd7, 32'h0);
        checkOutput("zero_f7", {31'b0, zeroFlag}, 32'd1);
        checkOutput("carry_f7", {31'b0, carryOut}, 32'd0);
`endif

        // Hold: drive different data with in_valid low. The last result stays.
        runOp("pre_hold", 32'h12345678, 5'd4, 3'd5, 32'h81234567);
        applyStimulus(1'b0, 32'hDEADBEEF, 5'd3, 3'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput($sformatf("hold_out_%0d", c), shiftOut, 32'h81234567);
            checkOutput($sformatf("hold_valid_%0d", c), {31'b0, outValid}, 32'h0);
        end

        // Assert reset in mid-cycle just after a result is captured. The
        // outputs must clear at once.
        applyStimulus(1'b1, 32'h35FFFF15, 5'd8, 3'd4);
        @(posedge clock);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async_rst_out", shiftOut, 32'h0);
        checkOutput("async_rst_valid", {31'b0, outValid}, 32'h0);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        checkOutput("post_rst_out", shiftOut, 32'hFFFF1535);
        checkOutput("post_rst_valid", {31'b0, outValid}, 32'h1);

        applyStimulus(1'b0, 32'h0, 5'd0, 3'd0);
        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
